// File: rtl/wb_signature_unit.sv
// Write-back observation unit: folds accepted WBout samples into a rotate-XOR
// signature and a saturating count, and buffers them in a drainable FIFO.
module wb_signature_unit #(
    parameter int DEPTH          = 8,
    parameter int CNT_W          = 16,
    parameter bit FILTER_REPEATS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              wb_data,
    input  logic                     wb_valid,
    input  logic                     capture_en,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              signature,
    output logic [CNT_W-1:0]         sample_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_MAX - CNT_ONE;
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [AW:0]      LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   last_accepted;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;

    logic          presented;
    logic          is_repeat;
    logic          accepted;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    // A non-zero count doubles as "something has been accepted since reset",
    // since the count saturates rather than wrapping back to zero.
    assign presented = (state == RUN) && capture_en && wb_valid;
    assign is_repeat = FILTER_REPEATS && (sample_count != '0) && (wb_data == last_accepted);
    assign accepted  = presented && !is_repeat;

    assign fifo_full = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = accepted && (!fifo_full || pop);
    assign drop      = accepted && fifo_full && !pop;

    // Masking keeps out_data at zero while empty, regardless of stale storage.
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (capture_en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accepted && (sample_count == CNT_LAST)) begin
                    state_next = SAT;
                end else if (!capture_en) begin
                    state_next = IDLE;
                end
            end
            SAT: begin
                state_next = SAT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signature     <= '0;
            sample_count  <= '0;
            last_accepted <= '0;
            overflow      <= 1'b0;
        end else begin
            if (accepted) begin
                signature     <= {signature[30:0], signature[31]} ^ wb_data;
                last_accepted <= wb_data;
                if (sample_count != CNT_MAX) begin
                    sample_count <= sample_count + CNT_ONE;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Pointers are log2(DEPTH) wide, so wrap-around is just natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !push) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_wb_signature_unit.sv
// Bench for wb_signature_unit: two instances (no filter / CNT_W=16, and
// filter / CNT_W=4) share stimulus and are scored against a queue-based model.
module tb_wb_signature_unit;

    localparam int DEPTH  = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_SAT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_data = '0;
    logic        wb_valid = 1'b0;
    logic        capture_en = 1'b0;
    logic        out_ready = 1'b0;

    logic [31:0] out_data_a, signature_a, out_data_b, signature_b;
    logic        out_valid_a, overflow_a, out_valid_b, overflow_b;
    logic [15:0] sample_count_a;
    logic [3:0]  sample_count_b;
    logic [3:0]  fifo_level_a, fifo_level_b;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int          filt [2] = '{0, 1};
    int          cmax [2] = '{65535, 15};
    int          m_state [2];
    int          m_cnt [2];
    logic [31:0] m_sig [2];
    logic [31:0] m_last [2];
    bit          m_ovf [2];
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    wb_signature_unit #(.DEPTH(DEPTH), .CNT_W(16), .FILTER_REPEATS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .wb_data(wb_data), .wb_valid(wb_valid),
        .capture_en(capture_en), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .signature(signature_a), .sample_count(sample_count_a),
        .fifo_level(fifo_level_a), .overflow(overflow_a)
    );

    wb_signature_unit #(.DEPTH(DEPTH), .CNT_W(4), .FILTER_REPEATS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .wb_data(wb_data), .wb_valid(wb_valid),
        .capture_en(capture_en), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .signature(signature_b), .sample_count(sample_count_b),
        .fifo_level(fifo_level_b), .overflow(overflow_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = S_IDLE;
            m_cnt[i]   = 0;
            m_sig[i]   = '0;
            m_last[i]  = '0;
            m_ovf[i]   = 1'b0;
        end
        mq0.delete();
        mq1.delete();
        sb0.delete();
        sb1.delete();
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic modelStep(input int i);
        logic [31:0] q [$];
        int          lvl;
        bit          pop;
        bit          acc;
        if (i == 0) q = mq0; else q = mq1;
        lvl = q.size();
        pop = (lvl > 0) && out_ready;
        acc = (m_state[i] == S_RUN) && capture_en && wb_valid &&
              !(filt[i] == 1 && m_cnt[i] > 0 && wb_data == m_last[i]);
        case (m_state[i])
            S_IDLE: if (capture_en) m_state[i] = S_RUN;
            S_RUN: begin
                if (acc && (m_cnt[i] + 1 == cmax[i])) m_state[i] = S_SAT;
                else if (!capture_en) m_state[i] = S_IDLE;
            end
            default: m_state[i] = S_SAT;
        endcase
        if (pop) void'(q.pop_front());
        if (acc) begin
            m_sig[i]  = ((m_sig[i] << 1) | (m_sig[i] >> 31)) ^ wb_data;
            m_last[i] = wb_data;
            if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            if (lvl < DEPTH || pop) begin
                q.push_back(wb_data);
                if (i == 0) sb0.push_back(wb_data); else sb1.push_back(wb_data);
            end else begin
                m_ovf[i] = 1'b1;
            end
        end
        if (i == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic checkOutput();
        check("sig_a",   signature_a,           m_sig[0]);
        check("cnt_a",   32'(sample_count_a),   m_cnt[0]);
        check("level_a", 32'(fifo_level_a),     mq0.size());
        check("ovf_a",   32'(overflow_a),       32'(m_ovf[0]));
        check("valid_a", 32'(out_valid_a),      32'(mq0.size() > 0));
        check("head_a",  out_data_a,            (mq0.size() > 0) ? mq0[0] : 32'h0);
        check("sig_b",   signature_b,           m_sig[1]);
        check("cnt_b",   32'(sample_count_b),   m_cnt[1]);
        check("level_b", 32'(fifo_level_b),     mq1.size());
        check("ovf_b",   32'(overflow_b),       32'(m_ovf[1]));
        check("valid_b", 32'(out_valid_b),      32'(mq1.size() > 0));
        check("head_b",  out_data_b,            (mq1.size() > 0) ? mq1[0] : 32'h0);
    endtask

    // Called 1 ns after a rising edge; leaves the bench at the same phase.
    task automatic applyStimulus(input bit cap, input bit valid, input logic [31:0] data, input bit ready);
        capture_en = cap;
        wb_valid   = valid;
        wb_data    = data;
        out_ready  = ready;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Mid-cycle 1 ns reset pulse; outputs must clear without a clock edge.
    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Scoreboard monitor: a head that is about to be popped must match the
    // oldest expected sample.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_a && out_ready) begin
                checks++;
                if (sb0.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pop_a: actual %h required none (queue empty)", out_data_a);
                end else begin
                    mon_exp = sb0.pop_front();
                    if (out_data_a !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL pop_a: actual %h required %h", out_data_a, mon_exp);
                    end
                end
            end
            if (out_valid_b && out_ready) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pop_b: actual %h required none (queue empty)", out_data_b);
                end else begin
                    mon_exp = sb1.pop_front();
                    if (out_data_b !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL pop_b: actual %h required %h", out_data_b, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        doReset();

        // Entry cycle is not sampled; then 1, 2 -> signature 1 then 0.
        applyStimulus(1'b1, 1'b1, 32'hdead_beef, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h1, 1'b1);
        check("arith_sig_1", signature_a, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h2, 1'b1);
        check("arith_sig_0", signature_a, 32'h0);
        check("arith_cnt_2", 32'(sample_count_a), 32'd2);

        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b1);
        check("arith_sig_msb", signature_a, 32'h8000_0000);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
        check("arith_sig_rot", signature_a, 32'h1);

        // Repeat filter: first 0 accepted, then 5,5,5,7.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h5, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h5, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h5, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h7, 1'b0);
        check("filter_cnt_b", 32'(sample_count_b), 32'd3);
        check("filter_cnt_a", 32'(sample_count_a), 32'd5);
        drain(10);

        // Overflow: 10 distinct values into a stalled 8-deep FIFO.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 32'h100 + 32'(k), 1'b0);
        check("ovf_level", 32'(fifo_level_a), 32'd8);
        check("ovf_flag", 32'(overflow_a), 32'd1);
        check("ovf_cnt", 32'(sample_count_a), 32'd10);
        drain(10);

        // Full FIFO with simultaneous push and pop.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 32'h200 + 32'(k), 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h2ff, 1'b1);
        check("full_level", 32'(fifo_level_a), 32'd8);
        check("full_ovf", 32'(overflow_a), 32'd0);
        drain(10);

        // Empty FIFO with simultaneous push and pop.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1);
        check("empty_level", 32'(fifo_level_a), 32'd1);

        // Saturation at 15 for instance b, then reset mid-drain.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1, 32'h400 + 32'(k), k >= 12);
        check("sat_cnt_b", 32'(sample_count_b), 32'd15);
        check("sat_cnt_a", 32'(sample_count_a), 32'd20);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h999, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h998, 1'b1);
        check("sat_hold_b", 32'(sample_count_b), 32'd15);
        doReset();
        check("mid_reset_level", 32'(fifo_level_a), 32'd0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            if ($urandom_range(0, 39) == 0) doReset();
            d = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 3)) : $urandom();
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, d,
                          $urandom_range(0, 2) != 0);
        end
        drain(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
